// File: rtl/led_pattern_sequencer_pkg.sv
// ============================================================================
// Module   : led_seq_pkg
// Brief    : Shared types, seeds and the pattern-advance function for the
//            LED pattern sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_ALT    = 2'd3
    } mode_e;

    localparam logic [7:0] c_SEED_BINARY = 8'h00;
    localparam logic [7:0] c_SEED_CHASE  = 8'h01;
    localparam logic [7:0] c_SEED_BOUNCE = 8'h01;
    localparam logic [7:0] c_SEED_ALT    = 8'h55;

    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [7:0] led;
        logic       dir;
    } pattern_t;

    function automatic logic [7:0] seed_of(input mode_e m);
        logic [7:0] s;
        s = c_SEED_BINARY;
        case (m)
            MODE_BINARY: s = c_SEED_BINARY;
            MODE_CHASE:  s = c_SEED_CHASE;
            MODE_BOUNCE: s = c_SEED_BOUNCE;
            MODE_ALT:    s = c_SEED_ALT;
            default:     s = c_SEED_BINARY;
        endcase
        return s;
    endfunction

    // Bounce reverses at the endpoints so each endpoint is shown once per pass.
    function automatic pattern_t next_pattern(input mode_e m, input logic [7:0] led,
                                              input logic dir);
        pattern_t res;
        res.led = led;
        res.dir = dir;
        case (m)
            MODE_BINARY: res.led = led + 8'd1;
            MODE_CHASE:  res.led = {led[6:0], led[7]};
            MODE_BOUNCE: begin
                if (dir == c_DIR_LEFT) begin
                    if (led == 8'h80) begin
                        res.led = 8'h40;
                        res.dir = c_DIR_RIGHT;
                    end else begin
                        res.led = {led[6:0], 1'b0};
                    end
                end else begin
                    if (led == 8'h01) begin
                        res.led = 8'h02;
                        res.dir = c_DIR_LEFT;
                    end else begin
                        res.led = {1'b0, led[7:1]};
                    end
                end
            end
            MODE_ALT:    res.led = (led == 8'h55) ? 8'hAA : 8'h55;
            default:     res.led = led;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_sequencer_if.sv
// ============================================================================
// Module   : led_pattern_sequencer_if
// Brief    : Control and LED output bundle of the LED pattern sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface led_pattern_sequencer_if;

    logic       start;
    logic       pause;
    logic       clear;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [7:0] LED;
    logic       busy;
    logic       step_tick;

    modport master (
        output start, pause, clear, mode, speed,
        input  LED, busy, step_tick
    );

    modport slave (
        input  start, pause, clear, mode, speed,
        output LED, busy, step_tick
    );

endinterface

`default_nettype wire

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// ============================================================================
// Module   : step_prescaler
// Brief    : Step-rate counter; strobes o_adv when the programmed period ends.
// Revision : 1.0
// ============================================================================
`default_nettype none

module step_prescaler #(
    parameter int STEP_DIV = 2**23
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       i_en,
    input  wire logic       i_clr,
    input  wire logic [1:0] i_speed,
    output logic            o_adv
);

    localparam int c_W = $clog2(STEP_DIV);
    // STEP_DIV is a power of two, so (STEP_DIV >> s) - 1 equals all-ones >> s.
    localparam logic [c_W-1:0] c_MAX = c_W'(STEP_DIV - 1);

    logic [c_W-1:0] r_cnt;
    logic [c_W-1:0] w_limit;

    assign w_limit = c_MAX >> i_speed;
    assign o_adv   = i_en && (r_cnt >= w_limit);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_adv ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : Drives the 8-LED bank through animated patterns with
//            start/pause/clear control and a programmable step rate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int STEP_DIV = 2**23
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    led_pattern_sequencer_if.slave  io_bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_PAUSE = ST_PAUSE;

    logic [1:0] r_state;
    mode_e      r_mode;
    logic [7:0] r_led;
    logic       r_dir;
    logic       r_busy;
    logic       r_tick;

    logic       w_en;
    logic       w_clr;
    logic       w_adv;
    logic       w_go;
    mode_e      w_mode_in;
    pattern_t   w_next;

    // Counting stops on the edge where pause or clear is seen, so a pause
    // landing on the limit edge leaves the count at the limit for resume.
    assign w_en      = (r_state == S_RUN) && !io_bus.clear && !io_bus.pause;
    assign w_clr     = (r_state == S_IDLE) || io_bus.clear;
    assign w_go      = io_bus.start && !io_bus.pause && !io_bus.clear;
    assign w_mode_in = mode_e'(io_bus.mode);
    assign w_next    = next_pattern(r_mode, r_led, r_dir);

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_en),
        .i_clr    (w_clr),
        .i_speed  (io_bus.speed),
        .o_adv    (w_adv)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_BINARY;
            r_led   <= 8'h00;
            r_dir   <= c_DIR_LEFT;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led <= 8'h00;
                    if (w_go) begin
                        r_state <= S_RUN;
                        r_mode  <= w_mode_in;
                        r_led   <= seed_of(w_mode_in);
                        r_dir   <= c_DIR_LEFT;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (io_bus.clear) begin
                        r_state <= S_IDLE;
                        r_led   <= 8'h00;
                        r_dir   <= c_DIR_LEFT;
                        r_busy  <= 1'b0;
                    end else if (io_bus.pause) begin
                        r_state <= S_PAUSE;
                    end else if (w_adv) begin
                        r_led  <= w_next.led;
                        r_dir  <= w_next.dir;
                        r_tick <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (io_bus.clear) begin
                        r_state <= S_IDLE;
                        r_led   <= 8'h00;
                        r_dir   <= c_DIR_LEFT;
                        r_busy  <= 1'b0;
                    end else if (w_go) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_led   <= 8'h00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.LED       = r_led;
    assign io_bus.busy      = r_busy;
    assign io_bus.step_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Brief    : Self-checking bench: step-count reference model plus directed
//            literal checks and randomized control stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

    localparam int STEP_DIV = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_pattern_sequencer_if bus ();

    led_pattern_sequencer #(
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: LED is a function of the latched mode and the number of
    // steps taken since start; timing tracks elapsed counting cycles.
    int   m_st    = 0;   // 0 idle, 1 run, 2 pause
    int   m_mode  = 0;
    int   m_k     = 0;
    int   m_el    = 0;
    bit   m_tick  = 1'b0;
    bit   m_valid = 1'b0;
    logic [7:0] bounce_tbl [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    function automatic logic [7:0] exp_led();
        logic [7:0] v;
        if (m_st == 0) return 8'h00;
        case (m_mode)
            0:       v = 8'(m_k % 256);
            1:       v = 8'(1 << (m_k % 8));
            2:       v = bounce_tbl[m_k % 14];
            default: v = ((m_k % 2) == 1) ? 8'hAA : 8'h55;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        int period;
        period = STEP_DIV >> bus.speed;
        if (!rst_n) begin
            m_st = 0; m_mode = 0; m_k = 0; m_el = 0; m_tick = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_tick = 1'b0;
            case (m_st)
                0: if (!bus.clear && !bus.pause && bus.start) begin
                       m_st = 1; m_mode = int'(bus.mode); m_k = 0; m_el = 0;
                   end
                1: if (bus.clear) begin
                       m_st = 0; m_el = 0;
                   end else if (bus.pause) begin
                       m_st = 2;
                   end else if (m_el + 1 >= period) begin
                       m_el = 0; m_k++; m_tick = 1'b1;
                   end else begin
                       m_el++;
                   end
                default: if (bus.clear) begin
                       m_st = 0; m_el = 0;
                   end else if (!bus.pause && bus.start) begin
                       m_st = 1;
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_vec++;
            if (bus.LED !== exp_led() || bus.busy !== (m_st != 0) || bus.step_tick !== m_tick) begin
                n_err++;
                $display("FAIL cycle t=%0t LED=%h exp=%h busy=%b exp=%b tick=%b exp=%b",
                         $time, bus.LED, exp_led(), bus.busy, (m_st != 0), bus.step_tick, m_tick);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        bus.mode  = 2'd0; bus.speed = 2'd0;
        cyc(3);
        chk("reset_led",  bus.LED, 8'h00);
        chk("reset_busy", {7'd0, bus.busy}, 8'h00);
        chk("reset_tick", {7'd0, bus.step_tick}, 8'h00);
        rst_n = 1'b1;
        cyc(1);

        // BINARY at speed 0: first step 16 edges after start, wrap after 256
        pulse_start();
        chk("bin_seed", bus.LED, 8'h00);
        chk("bin_busy", {7'd0, bus.busy}, 8'h01);
        cyc(15);
        chk("bin_before_step", bus.LED, 8'h00);
        cyc(1);
        chk("bin_step1", bus.LED, 8'h01);
        chk("bin_tick1", {7'd0, bus.step_tick}, 8'h01);
        cyc(16);
        chk("bin_step2", bus.LED, 8'h02);
        cyc(16 * 254);
        chk("bin_wrap", bus.LED, 8'h00);
        chk("bin_wrap_tick", {7'd0, bus.step_tick}, 8'h01);

        // CHASE at speed 2
        pulse_clear();
        bus.mode = 2'd1; bus.speed = 2'd2;
        pulse_start();
        chk("chase_seed", bus.LED, 8'h01);
        cyc(4);
        chk("chase_step1", bus.LED, 8'h02);
        cyc(28);
        chk("chase_wrap", bus.LED, 8'h01);

        // BOUNCE full pass at speed 0
        pulse_clear();
        bus.mode = 2'd2; bus.speed = 2'd0;
        pulse_start();
        chk("bounce_seed", bus.LED, 8'h01);
        cyc(16 * 7);
        chk("bounce_top", bus.LED, 8'h80);
        cyc(16);
        chk("bounce_turn", bus.LED, 8'h40);
        cyc(16 * 6);
        chk("bounce_bottom", bus.LED, 8'h01);
        cyc(16);
        chk("bounce_again", bus.LED, 8'h02);

        // ALT with pause mid-period and resume from the frozen count
        pulse_clear();
        bus.mode = 2'd3;
        pulse_start();
        chk("alt_seed", bus.LED, 8'h55);
        cyc(16);
        chk("alt_step1", bus.LED, 8'hAA);
        cyc(5);
        bus.pause = 1'b1;
        cyc(50);
        chk("alt_paused", bus.LED, 8'hAA);
        chk("alt_paused_busy", {7'd0, bus.busy}, 8'h01);
        bus.pause = 1'b0;
        pulse_start();
        cyc(10);
        chk("alt_resume_hold", bus.LED, 8'hAA);
        cyc(1);
        chk("alt_resume_step", bus.LED, 8'h55);
        chk("alt_resume_tick", {7'd0, bus.step_tick}, 8'h01);

        // clear beats pause and start
        bus.clear = 1'b1; bus.pause = 1'b1; bus.start = 1'b1;
        cyc(1);
        bus.clear = 1'b0; bus.pause = 1'b0; bus.start = 1'b0;
        chk("prio_led",  bus.LED, 8'h00);
        chk("prio_busy", {7'd0, bus.busy}, 8'h00);

        // mode change mid-run is ignored
        bus.mode = 2'd1;
        pulse_start();
        bus.mode = 2'd0;
        cyc(16);
        chk("mode_ignored", bus.LED, 8'h02);

        // reset mid-run
        cyc(5);
        rst_n = 1'b0;
        cyc(1);
        chk("rst_mid_led",  bus.LED, 8'h00);
        chk("rst_mid_busy", {7'd0, bus.busy}, 8'h00);
        chk("rst_mid_tick", {7'd0, bus.step_tick}, 8'h00);
        rst_n = 1'b1;

        // randomized control traffic against the model
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 15) == 0);
            bus.pause = ($urandom_range(0, 40) == 0);
            bus.clear = ($urandom_range(0, 150) == 0);
            bus.mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) bus.speed = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
